// File: rtl/mc_timer_mailbox.sv
// MCU async-bus mailbox: SRAM window plus a compare timer with level interrupts.
// Optional define MC_TIMER_AUTORELOAD_EN restarts the counter on a channel-0 match.
module mc_timer_mailbox #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int NUM_IRQ       = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_din,
  output logic [MC_DATA_WIDTH-1:0] mc_dout,
  output logic                     mc_data_oe,
  output logic [NUM_IRQ-1:0]       irq_n
);

  localparam int OFF_W = MC_ADD_WIDTH - 1;
  localparam int DEPTH = 2 ** OFF_W;

  logic [2:0]               strb_s1, strb_s2;
  logic [MC_ADD_WIDTH-1:0]  add_s1, add_s2;
  logic [MC_DATA_WIDTH-1:0] din_s1, din_s2;
  logic                     is_write, is_read, prev_write, commit;
  logic                     reg_space;
  logic [OFF_W-1:0]         offset;
  logic                     wr_sram, wr_ctrl, wr_stat, wr_mask;
  logic [NUM_IRQ-1:0]       wr_cmp, match, w1c;
  logic                     run;
  logic [NUM_IRQ-1:0]       stat, mask;
  logic [MC_DATA_WIDTH-1:0] count;
  logic [MC_DATA_WIDTH-1:0] cmp [NUM_IRQ];
  logic [MC_DATA_WIDTH-1:0] mem [DEPTH];
  logic [MC_DATA_WIDTH-1:0] rd_data;

  // Strobes idle high so reset can never be mistaken for a bus access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      strb_s1 <= '1;
      strb_s2 <= '1;
    end else begin
      strb_s1 <= {mc_ce, mc_oe, mc_we};
      strb_s2 <= strb_s1;
    end
  end

  always_ff @(posedge clock) begin
    add_s1 <= mc_add;
    add_s2 <= add_s1;
    din_s1 <= mc_din;
    din_s2 <= din_s1;
  end

  assign is_write  = (strb_s2 == 3'b010);
  assign is_read   = (strb_s2 == 3'b001);
  assign commit    = reset & is_write & ~prev_write;
  assign reg_space = add_s2[MC_ADD_WIDTH-1];
  assign offset    = add_s2[OFF_W-1:0];
  assign wr_sram   = commit & ~reg_space;
  assign wr_ctrl   = commit & reg_space & (offset == OFF_W'(0));
  assign wr_stat   = commit & reg_space & (offset == OFF_W'(1));
  assign wr_mask   = commit & reg_space & (offset == OFF_W'(2));
  assign w1c       = wr_stat ? din_s2[NUM_IRQ-1:0] : '0;

  always_comb begin
    for (int n = 0; n < NUM_IRQ; n++) begin
      wr_cmp[n] = commit & reg_space & (offset == OFF_W'(4 + n));
      match[n]  = run & (count == cmp[n]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) prev_write <= 1'b0;
    else        prev_write <= is_write;
  end

  // CLR beats reload, reload beats increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_ctrl && din_s2[1]) begin
      count <= '0;
`ifdef MC_TIMER_AUTORELOAD_EN
    end else if (match[0]) begin
      count <= '0;
`endif
    end else if (run) begin
      count <= count + MC_DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run   <= 1'b0;
      mask  <= '0;
      stat  <= '0;
      irq_n <= '1;
      for (int n = 0; n < NUM_IRQ; n++) cmp[n] <= '1;
    end else begin
      if (wr_ctrl) run <= din_s2[0];
      if (wr_mask) mask <= din_s2[NUM_IRQ-1:0];
      stat  <= (stat & ~w1c) | match;
      irq_n <= ~(stat & mask);
      for (int n = 0; n < NUM_IRQ; n++)
        if (wr_cmp[n]) cmp[n] <= din_s2;
    end
  end

  // Mailbox contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_sram) mem[offset] <= din_s2;
  end

  always_comb begin
    rd_data = '0;
    if (!reg_space) begin
      rd_data = mem[offset];
    end else begin
      case (offset)
        OFF_W'(0): rd_data[0] = run;
        OFF_W'(1): rd_data[NUM_IRQ-1:0] = stat;
        OFF_W'(2): rd_data[NUM_IRQ-1:0] = mask;
        OFF_W'(3): rd_data = count;
        default:   ;
      endcase
      for (int n = 0; n < NUM_IRQ; n++)
        if (offset == OFF_W'(4 + n)) rd_data = cmp[n];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mc_data_oe <= 1'b0;
      mc_dout    <= '0;
    end else begin
      mc_data_oe <= is_read;
      if (is_read) mc_dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_mc_timer_mailbox.sv
// Randomized scoreboard bench for mc_timer_mailbox against a register-level reference model.
`timescale 1ns/1ps
module tb_mc_timer_mailbox;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NI = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mc_ce = 1'b1, mc_oe = 1'b1, mc_we = 1'b1;
  logic [AW-1:0] mc_add = '0;
  logic [DW-1:0] mc_din = '0;
  logic [DW-1:0] mc_dout;
  logic          mc_data_oe;
  logic [NI-1:0] irq_n;

  mc_timer_mailbox #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW), .NUM_IRQ(NI)) dut (
    .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_din(mc_din), .mc_dout(mc_dout),
    .mc_data_oe(mc_data_oe), .irq_n(irq_n)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // reference model of the programmer-visible state
  bit            m_run;
  logic [NI-1:0] m_stat, m_mask, m_irq;
  logic [DW-1:0] m_count;
  logic [DW-1:0] m_cmp [NI];
  logic [DW-1:0] m_sram [32];
  bit            m_sram_ok [32];
  bit            m_oe, m_s1, m_s2;

  bit            wr_pend = 0, rd_pend = 0;
  logic [AW-1:0] pend_add = '0;
  logic [DW-1:0] pend_dat = '0;
  logic [DW-1:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    int off;
    off = int'(a[AW-2:0]);
    if (!a[AW-1]) return m_sram[off];
    if (off == 0) return DW'(m_run);
    if (off == 1) return DW'(m_stat);
    if (off == 2) return DW'(m_mask);
    if (off == 3) return m_count;
    if (off >= 4 && off < 4 + NI) return m_cmp[off-4];
    return '0;
  endfunction

  always @(posedge clock) begin
    logic [NI-1:0] hit, clr;
    int off;
    bit regs;
    if (!reset) begin
      m_run = 0; m_stat = '0; m_mask = '0; m_count = '0; m_irq = '1;
      m_oe = 0; m_s1 = 0; m_s2 = 0;
      for (int n = 0; n < NI; n++) m_cmp[n] = '1;
    end else begin
      if (rd_pend) exp_q.push_back(model_read(pend_add));
      m_oe = m_s2;
      m_s2 = m_s1;
      m_s1 = (!mc_ce && mc_we && !mc_oe);
      m_irq = ~(m_stat & m_mask);
      for (int n = 0; n < NI; n++) hit[n] = m_run && (m_count == m_cmp[n]);
      regs = pend_add[AW-1];
      off  = int'(pend_add[AW-2:0]);
      clr  = (wr_pend && regs && off == 1) ? pend_dat[NI-1:0] : '0;
      if (wr_pend && regs && off == 0 && pend_dat[1]) m_count = '0;
`ifdef MC_TIMER_AUTORELOAD_EN
      else if (hit[0]) m_count = '0;
`endif
      else if (m_run) m_count = m_count + DW'(1);
      m_stat = (m_stat & ~clr) | hit;
      if (wr_pend) begin
        if (!regs) begin
          m_sram[off] = pend_dat;
          m_sram_ok[off] = 1;
        end else if (off == 0) m_run = pend_dat[0];
        else if (off == 2) m_mask = pend_dat[NI-1:0];
        else if (off >= 4 && off < 4 + NI) m_cmp[off-4] = pend_dat;
      end
    end
  end

  // monitor: checks outputs every cycle, pops the scoreboard when a read starts driving
  bit oe_prev = 0;
  always @(negedge clock) begin
    if (chk_en) begin
      checkOutput("data_oe", 32'(mc_data_oe), 32'(m_oe));
      checkOutput("irq_n", 32'(irq_n), 32'(m_irq));
      if (mc_data_oe && !oe_prev) begin
        checkOutput("read_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) checkOutput("read_data", 32'(mc_dout), 32'(exp_q.pop_front()));
      end
      oe_prev = mc_data_oe;
    end
  end

  task automatic applyStimulus(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    mc_ce = 1'b0; mc_we = !is_wr; mc_oe = is_wr; mc_add = a; mc_din = d;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    pend_add = a; pend_dat = d;
    if (is_wr) wr_pend = 1; else rd_pend = 1;
    @(posedge clock);
    @(negedge clock);
    wr_pend = 0; rd_pend = 0;
    @(posedge clock);
    @(negedge clock);
    mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] tgt;
    int idx;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1;
    reset = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(0, AW'(32 + i), '0);

    applyStimulus(1, 6'd5, 16'hA55A);
    applyStimulus(0, 6'd5, '0);

    applyStimulus(1, 6'h24, 16'h0010);
    applyStimulus(1, 6'h22, 16'h0001);
    applyStimulus(1, 6'h20, 16'h0001);
    repeat (30) @(posedge clock);
    applyStimulus(0, 6'h21, '0);
    applyStimulus(1, 6'h21, 16'h0001);
    repeat (3) @(posedge clock);
    applyStimulus(0, 6'h21, '0);
    applyStimulus(1, 6'h20, 16'h0000);

    applyStimulus(1, 6'h22, 16'h0000);
    applyStimulus(1, 6'h20, 16'h0003);
    repeat (25) @(posedge clock);
    applyStimulus(0, 6'h21, '0);
    applyStimulus(1, 6'h22, 16'h0001);
    repeat (3) @(posedge clock);
    applyStimulus(1, 6'h21, 16'h0003);
    applyStimulus(1, 6'h20, 16'h0000);

    // line up a STAT[1] clear with the exact clock of a CMP[1] match
    applyStimulus(1, 6'h24, 16'hFFFF);
    applyStimulus(1, 6'h21, 16'h0003);
    applyStimulus(1, 6'h20, 16'h0003);
    @(negedge clock);
    tgt = m_count + DW'(30);
    applyStimulus(1, 6'h25, tgt);
    for (int i = 0; i < 200 && m_count != tgt - DW'(3); i++) @(negedge clock);
    if (m_count != tgt - DW'(3)) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL align_wait: count %0h never reached %0h", m_count, tgt - DW'(3));
    end
    applyStimulus(1, 6'h21, 16'h0002);
    applyStimulus(0, 6'h21, '0);
    applyStimulus(1, 6'h20, 16'h0000);
    applyStimulus(1, 6'h21, 16'h0003);

    applyStimulus(1, 6'h24, 16'h0003);
    applyStimulus(1, 6'h20, 16'h0003);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      applyStimulus(0, 6'h23, '0);
    end
`ifndef MC_TIMER_AUTORELOAD_EN
    for (int i = 0; i < 70000 && m_count != 16'hFFF8; i++) @(negedge clock);
    if (m_count != 16'hFFF8) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL wrap_wait: count %0h never reached fff8", m_count);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 6'h23, '0);
`endif
    applyStimulus(1, 6'h20, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: begin
          if (idx == 5) idx = 6;
          applyStimulus(1, {1'b0, 5'(idx)}, DW'($urandom));
        end
        1: begin
          if (!m_sram_ok[idx]) idx = 5;
          applyStimulus(0, {1'b0, 5'(idx)}, '0);
        end
        2: begin
          idx = ($urandom_range(0, 3) == 0) ? idx : $urandom_range(0, 5);
          applyStimulus(1, {1'b1, 5'(idx)}, DW'($urandom));
        end
        default: applyStimulus(0, {1'b1, 5'($urandom_range(0, 31))}, '0);
      endcase
      repeat ($urandom_range(0, 4)) @(posedge clock);
    end

    // reset lands while a read is actively driving the pads
    applyStimulus(1, 6'h22, 16'h0003);
    applyStimulus(1, 6'h20, 16'h0001);
    @(negedge clock);
    mc_ce = 1'b0; mc_we = 1'b1; mc_oe = 1'b0; mc_add = 6'd5;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    pend_add = 6'd5; rd_pend = 1;
    @(posedge clock);
    @(negedge clock);
    rd_pend = 0;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_data_oe", 32'(mc_data_oe), 32'(0));
    checkOutput("rst_dout", 32'(mc_dout), 32'(0));
    checkOutput("rst_irq_n", 32'(irq_n), 32'({NI{1'b1}}));
    mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    applyStimulus(0, 6'h23, '0);
    applyStimulus(0, 6'd5, '0);
    applyStimulus(0, 6'h21, '0);

    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
